// File: rtl/ins_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
package ins_fetch_queue_pkg;

    // addi x0,x0,0 -- decodes as a harmless bubble when the queue is empty
    localparam logic [31:0] NOP_INS = 32'h00000013;

    localparam int DEFAULT_DEPTH = 4;

    // One buffered entry: instruction word in the upper half, PC in the lower half
    localparam int ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } entry_t;

endpackage

// File: rtl/ins_fetch_queue_storage.sv
// DEPTH x ENTRY_W register array: synchronous write, asynchronous read, no reset.
module fq_storage
    import ins_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTRW  = 2
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTRW-1:0]    waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [PTRW-1:0]    raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write the addressed slot on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ins_fetch_queue.sv
// Fetch-to-decode decoupling FIFO of {instruction, PC} pairs with flush.
module ins_fetch_queue
    import ins_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTRW  = 2,
    parameter int CNTW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [31:0]     in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ins,
    output logic [31:0]     out_pc,
    input  logic            flush,
    output logic [CNTW-1:0] count
);

    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            push;
    logic            pop;
    entry_t          wr_entry;
    entry_t          rd_entry;

    // Full/empty come only from count; pointers are equal in both cases
    assign in_ready  = !reset && (count != CNTW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_entry.ins = in_ins;
    assign wr_entry.pc  = in_pc;

    fq_storage #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_storage (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Pointer and occupancy update; flush overrides any same-cycle push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry when valid, otherwise a NOP bubble at PC 0
    always_comb begin
        out_ins = NOP_INS;
        out_pc  = '0;
        if (out_valid) begin
            out_ins = rd_entry.ins;
            out_pc  = rd_entry.pc;
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Self-checking bench for ins_fetch_queue: queue-based reference model plus directed checks.
module tb_ins_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        flush;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    // Reference contents: element 0 is the head, each element is {ins, pc}
    logic [63:0] mq [$];

    ins_fetch_queue #(
        .DEPTH (4),
        .PTRW  (2),
        .CNTW  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ins    (in_ins),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ins   (out_ins),
        .out_pc    (out_pc),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: reset or flush empties; otherwise accept/consume by the handshake rules
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = out_ready && (mq.size() != 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({in_ins, in_pc});
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        e_ins = NOP;
        e_pc  = '0;
        if (mq.size() != 0) begin
            e_ins = mq[0][63:32];
            e_pc  = mq[0][31:0];
        end
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("m_in_ready", 64'(in_ready), 64'(!reset && mq.size() < DEPTH));
        chk("m_out_ins", 64'(out_ins), 64'(e_ins));
        chk("m_out_pc", 64'(out_pc), 64'(e_pc));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill_ins [4];
    logic [31:0] pend_ins [2];

    initial begin
        int k;
        fill_ins[0] = 32'h00500093;
        fill_ins[1] = 32'h00A00113;
        fill_ins[2] = 32'h002081B3;
        fill_ins[3] = 32'h00302023;
        pend_ins[0] = 32'h00000463;
        pend_ins[1] = 32'h0040006F;

        reset = 1'b1; in_valid = 1'b0; in_ins = '0; in_pc = '0;
        out_ready = 1'b0; flush = 1'b0;
        step();
        step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ins", 64'(out_ins), 64'h00000013);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        reset = 1'b0;

        // Fill to capacity with decode stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_ins = fill_ins[i]; in_pc = 32'(4 * i);
            step();
        end
        in_valid = 1'b0;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_out_ins", 64'(out_ins), 64'h00500093);
        chk("fill_out_pc", 64'(out_pc), 64'd0);

        // Drain six with two more pushed as space opens; pointers wrap
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            bit took;
            chk("drain_order_pc", 64'(out_pc), 64'(4 * c));
            in_valid = (k < 2);
            in_ins = (k < 2) ? pend_ins[k] : 32'h0;
            in_pc = 32'(16 + 4 * k);
            took = in_valid && in_ready;
            step();
            if (took) k++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_out_ins", 64'(out_ins), 64'h00000013);

        // Simultaneous push and pop at count=2
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_ins = 32'h11110000 + 32'(i); in_pc = 32'h100 + 32'(4 * i);
            step();
        end
        in_valid = 1'b1; in_ins = 32'h11110002; in_pc = 32'h108; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pp_count", 64'(count), 64'd2);
        chk("pp_out_pc", 64'(out_pc), 64'h104);
        out_ready = 1'b1;
        step();
        chk("pp_next_pc", 64'(out_pc), 64'h108);
        step();
        out_ready = 1'b0;
        chk("pp_empty", 64'(count), 64'd0);

        // Flush at count=3 with a push in the same cycle
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_ins = 32'h22220000 + 32'(i); in_pc = 32'h200 + 32'(4 * i);
            step();
        end
        in_valid = 1'b1; in_ins = 32'h0DEAD013; in_pc = 32'h999; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_pc", 64'(out_pc), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fl_dropped", 64'(out_valid), 64'd0);

        // Full plus pop: no push that cycle, slot visible next cycle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_ins = 32'h33330000 + 32'(i); in_pc = 32'h300 + 32'(4 * i);
            step();
        end
        in_valid = 1'b1; in_ins = 32'h3333FFFF; in_pc = 32'h3FC; out_ready = 1'b1;
        chk("fp_in_ready_before", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("fp_in_ready_after", 64'(in_ready), 64'd1);
        chk("fp_count", 64'(count), 64'd3);
        chk("fp_head_pc", 64'(out_pc), 64'h304);
        out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        chk("fp_drained", 64'(count), 64'd0);

        // Asynchronous reset between edges at count=2
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_ins = 32'h44440000 + 32'(i); in_pc = 32'h400 + 32'(4 * i);
            step();
        end
        in_valid = 1'b0;
        chk("ar_count_before", 64'(count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_count_now", 64'(count), 64'd0);
        chk("ar_out_valid_now", 64'(out_valid), 64'd0);
        chk("ar_in_ready_now", 64'(in_ready), 64'd0);
        step();
        reset = 1'b0;
        in_valid = 1'b1; in_ins = 32'h55500093; in_pc = 32'h500;
        chk("ar_no_bypass", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        chk("ar_first_valid", 64'(out_valid), 64'd1);
        chk("ar_first_ins", 64'(out_ins), 64'h55500093);
        chk("ar_first_pc", 64'(out_pc), 64'h500);
        chk("ar_first_count", 64'(count), 64'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ins_fetch_queue.md
Name: ins_fetch_queue

Overview:
- Decoupling buffer between the fetch stage (PC register + instruction memory) and the decode stage (register file + immediate generation).
- Buffers {instruction, PC} pairs in a small circular FIFO with valid/ready handshakes on both sides, so fetch can run ahead of a stalled decode.
- A flush input discards all buffered entries on a taken branch, jump or interrupt redirect.
- When empty, presents a canonical NOP so downstream control decodes a harmless bubble.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTRW, 2, pointer width, equal to log2(DEPTH).
- CNTW, 3, occupancy counter width, equal to PTRW+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid entry.
- in_ready  output  1  queue accepts an entry this cycle.
- in_ins  input  32  fetched instruction word.
- in_pc  input  32  PC of the fetched instruction.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_ins  output  32  head instruction, or NOP when empty.
- out_pc  output  32  head PC, or 0 when empty.
- flush  input  1  discard all entries (redirect).
- count  output  CNTW  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high, named reset; clock named clk.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_ins=32'h00000013, out_pc=0, in_ready=0 while reset is high.
- Storage contents are not reset.
- Handshake rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = !reset & (count != DEPTH).
  - out_valid = (count != 0).
- Push: at the clock edge, write {in_ins, in_pc} to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: at the clock edge, rd_ptr increments modulo DEPTH.
- Output path: out_ins and out_pc read mem[rd_ptr] combinationally when out_valid=1; otherwise NOP (32'h00000013) and 0.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no same-cycle bypass, even when the queue is empty.
- Simultaneous push and pop (count between 1 and DEPTH-1): both take effect and count is unchanged.
- Full (count=DEPTH): in_ready=0, so no push. A pop in the same cycle frees a slot for the next cycle only; in_ready is not combinationally dependent on out_ready.
- Empty (count=0): out_valid=0, so out_ready is ignored. Pointers stay equal.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished only by count, never by pointer comparison.
- Flush has highest priority:
  - At the edge, wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in the same cycle is discarded; the pushed entry is dropped.
  - in_ready stays combinational per the rule above; flush does not gate it.
- Reset mid-operation: all state clears immediately (asynchronous). The first push is possible in the first cycle after reset deasserts.
- Invariant: count = number of pushes − pops since the last flush or reset, always within 0..DEPTH.

Decomposition:
- Shared package holds:
  - NOP_INS = 32'h00000013 (addi x0,x0,0).
  - Default DEPTH.
  - The entry width constant (64).
- One sub-module, fq_storage: DEPTH x 64 register array with synchronous write port and asynchronous read port, no reset.
- Pointer, count and handshake control stay in ins_fetch_queue.

Test Plan:
- Fill: reset, then push 0x00500093@pc0, 0x00A00113@pc4, 0x002081B3@pc8, 0x00302023@pc12 with out_ready=0 -> count=4, in_ready=0, out_ins=0x00500093, out_pc=0.
- Drain with wrap: from full, out_ready=1 for 6 cycles while pushing 0x00000463@pc16, 0x0040006F@pc20 -> outputs in order pc0,4,8,12,16,20; count ends 0; out_ins=0x00000013 when empty.
- Simultaneous push/pop at count=2 -> count stays 2; order preserved; pointers advance by one each.
- Flush with in_valid=1 at count=3 -> next cycle count=0, out_valid=0, out_pc=0; the pushed entry is not observable afterwards.
- Full plus pop: count=4, out_ready=1, in_valid=1 -> no push that cycle; next cycle in_ready=1 and count=3.
- Async reset mid-stream: assert reset between edges at count=2 -> count=0 and out_valid=0 immediately; first push after release appears at the outputs one cycle later.
